neuron_mac_sched: RTL and testbench
===================================

Name: neuron_mac_sched

Overview:
Sequencer for one neuron's dot product that time-shares a single external 5-bit sign-magnitude multiplier (4-bit magnitude, bit 4 = sign, 10-bit sign-magnitude product).
- On start, it walks N_INPUTS input/weight pairs by index, drives registered operands to the multiplier, and converts each product to two's complement.
- It accumulates the products with saturation and pulses done.
- It sits between the neuron's input/weight storage and the activation stage.

Parameters:
N_INPUTS, 4, number of input/weight pairs per dot product (1 to 2^IDX_W)
IDX_W, 2, width of the pair index
ACC_W, 12, signed accumulator width (two's complement, at least 9)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a dot product; sampled only in IDLE
x_in  input  5  sign-magnitude input selected by idx (combinational, valid same cycle)
w_in  input  5  sign-magnitude weight selected by idx (combinational, valid same cycle)
idx  output  IDX_W  current pair index, registered
mult_a  output  5  registered operand to multiplier a
mult_b  output  5  registered operand to multiplier b
mult_p  input  10  combinational multiplier product of mult_a, mult_b
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse, result valid
acc_out  output  ACC_W  signed accumulated result, held until next accepted start
sat  output  1  saturation occurred during current/last operation; sticky until next start

Behaviour:
- Reset: state=IDLE; idx, mult_a, mult_b, acc_out all 0; busy, done, sat 0; pending flag pv=0. Reset mid-operation aborts immediately, with no done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN; idx<=0, acc_out<=0, sat<=0, pv<=0.
  - start=0 -> stay in IDLE.
- RUN, with idx=k, at each edge:
  - mult_a<=x_in; mult_b<=w_in; pv<=1.
  - If pv=1, accumulate conv(mult_p).
  - If k==N_INPUTS-1 -> DRAIN; else idx<=k+1.
- DRAIN: accumulate conv(mult_p) for the last pair; pv<=0 -> DONE.
- DONE: done=1 for exactly this cycle; busy=0 -> IDLE next edge. idx returns to 0 on leaving DONE.
- start in RUN, DRAIN or DONE is ignored; there is no queuing.
- Timing: start accepted at edge t gives RUN cycles t+1..t+N_INPUTS, DRAIN at t+N_INPUTS+1, done high in cycle t+N_INPUTS+2.
- Multiplier latency is one registered stage: the product of the pair issued in cycle c is consumed at the edge ending cycle c+1.
- conv(p):
  - Magnitude = p[7:0], zero-extended (max 225; p[8] ignored).
  - Negate if p[9]=1.
  - Sign bit set with zero magnitude (negative zero) contributes 0.
- Accumulate: compute acc+conv at ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1: clamp to max, sat<=1.
  - Below -2^(ACC_W-1): clamp to min, sat<=1.
  - Subsequent terms continue from the clamped value.
- N_INPUTS=1: a single RUN cycle, then DRAIN, DONE; done arrives 3 cycles after start.
- mult_a/mult_b hold their last values outside RUN.

Test Plan:
- N=4, x={+3,+5,-2,+15}, w={+2,-1,+7,+15} (-2=5'b10010) -> mult_a/mult_b follow pairs on idx 0..3; done in cycle t+6; acc_out=212 (12'h0D4); sat=0.
- x={5'b10000 (negative zero),+1,+1,+1}, w={+5,-1,-1,-1} -> acc_out=-3 (12'hFFD); first term contributes 0.
- ACC_W=8, all pairs +15*+15 -> clamp to 127, sat=1. All pairs +15*-15 -> acc_out=-128, sat=1. Next start clears sat.
- Pulse start in cycles t+2 and t+5 of a run -> both ignored; exactly one done at t+6; acc_out unchanged by the ignored starts.
- Assert rst in cycle t+3 of a run -> next cycle state IDLE, busy=0, acc_out=0, no done. A new start then gives correct result 212 with the first-scenario data.
- Back-to-back: start again the cycle after done -> accepted (IDLE); acc_out cleared to 0 at acceptance; second result correct.

Source files
------------

// File: rtl/neuron_mac_sched.sv
// neuron_mac_sched: sequences one neuron's dot product through a shared 5-bit sign-magnitude
// multiplier, accumulating two's-complement products with saturation.
module neuron_mac_sched #(
  parameter int N_INPUTS = 4,
  parameter int IDX_W = 2,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       x_in,
  input  logic [4:0]       w_in,
  output logic [IDX_W-1:0] idx,
  output logic [4:0]       mult_a,
  output logic [4:0]       mult_b,
  input  logic [9:0]       mult_p,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  // two guard bits keep acc + 225 exact even for narrow accumulators
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN = {3'b111, {(ACC_W-1){1'b0}}};
  state_t r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic [4:0] r_a, r_b;
  logic [ACC_W-1:0] r_acc;
  logic r_sat, r_pv;
  logic signed [SW-1:0] w_mag, w_term, w_sum;
  logic w_last, w_acc_en, w_hi, w_lo;
  assign w_last = r_idx == IDX_W'(N_INPUTS - 1);
  assign w_mag = {{(SW-8){1'b0}}, mult_p[7:0]};
  assign w_term = mult_p[9] ? -w_mag : w_mag;
  assign w_sum = {{2{r_acc[ACC_W-1]}}, r_acc} + w_term;
  assign w_hi = w_sum > MAX;
  assign w_lo = w_sum < MIN;
  assign w_acc_en = (r_state == RUN && r_pv) || r_state == DRAIN;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? DRAIN : RUN;
      DRAIN:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_sat <= 1'b0;
      r_pv <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_idx <= '0;
        r_acc <= '0;
        r_sat <= 1'b0;
        r_pv <= 1'b0;
      end
      if (r_state == RUN) begin
        r_a <= x_in;
        r_b <= w_in;
        r_pv <= 1'b1;
        if (!w_last) r_idx <= r_idx + 1'b1;
      end
      if (r_state == DRAIN) r_pv <= 1'b0;
      if (r_state == DONE) r_idx <= '0;
      if (w_acc_en) begin
        r_acc <= w_hi ? MAX[ACC_W-1:0] : w_lo ? MIN[ACC_W-1:0] : w_sum[ACC_W-1:0];
        if (w_hi || w_lo) r_sat <= 1'b1;
      end
    end
  end
  assign idx = r_idx;
  assign mult_a = r_a;
  assign mult_b = r_b;
  assign acc_out = r_acc;
  assign sat = r_sat;
  assign busy = r_state == RUN || r_state == DRAIN;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_neuron_mac_sched.sv
// tb_neuron_mac_sched: table, random and corner-case checks of three neuron_mac_sched
// configurations against an integer dot-product model.
module tb_neuron_mac_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] st = '0;
  logic [4:0] xd[4];
  logic [4:0] wd[4];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  function automatic logic [9:0] smul(input logic [4:0] a, input logic [4:0] b);
    logic [7:0] m;
    m = {4'b0, a[3:0]} * {4'b0, b[3:0]};
    return {a[4] ^ b[4], 1'b0, m};
  endfunction

  logic [1:0] idx0;
  logic [4:0] a0, b0, xi0, wi0;
  logic [9:0] p0;
  logic busy0, done0, sat0;
  logic [11:0] acc0;
  assign xi0 = xd[idx0];
  assign wi0 = wd[idx0];
  assign p0 = smul(a0, b0);
  neuron_mac_sched u0 (.clk(clk), .rst(rst), .start(st[0]), .x_in(xi0), .w_in(wi0),
    .idx(idx0), .mult_a(a0), .mult_b(b0), .mult_p(p0), .busy(busy0), .done(done0),
    .acc_out(acc0), .sat(sat0));

  logic [1:0] idx1;
  logic [4:0] a1, b1, xi1, wi1;
  logic [9:0] p1;
  logic busy1, done1, sat1;
  logic [7:0] acc1;
  assign xi1 = xd[idx1];
  assign wi1 = wd[idx1];
  assign p1 = smul(a1, b1);
  neuron_mac_sched #(.ACC_W(8)) u1 (.clk(clk), .rst(rst), .start(st[1]), .x_in(xi1),
    .w_in(wi1), .idx(idx1), .mult_a(a1), .mult_b(b1), .mult_p(p1), .busy(busy1),
    .done(done1), .acc_out(acc1), .sat(sat1));

  logic idx2;
  logic [4:0] a2, b2, xi2, wi2;
  logic [9:0] p2;
  logic busy2, done2, sat2;
  logic [11:0] acc2;
  assign xi2 = xd[{1'b0, idx2}];
  assign wi2 = wd[{1'b0, idx2}];
  assign p2 = smul(a2, b2);
  neuron_mac_sched #(.N_INPUTS(1), .IDX_W(1)) u2 (.clk(clk), .rst(rst), .start(st[2]),
    .x_in(xi2), .w_in(wi2), .idx(idx2), .mult_a(a2), .mult_b(b2), .mult_p(p2),
    .busy(busy2), .done(done2), .acc_out(acc2), .sat(sat2));

  function automatic int g_acc(input int s);
    return s == 0 ? int'($signed(acc0)) : s == 1 ? int'($signed(acc1)) : int'($signed(acc2));
  endfunction
  function automatic int g_done(input int s);
    return s == 0 ? int'(done0) : s == 1 ? int'(done1) : int'(done2);
  endfunction
  function automatic int g_busy(input int s);
    return s == 0 ? int'(busy0) : s == 1 ? int'(busy1) : int'(busy2);
  endfunction
  function automatic int g_sat(input int s);
    return s == 0 ? int'(sat0) : s == 1 ? int'(sat1) : int'(sat2);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sm2i(input logic [4:0] v);
    return v[4] ? -int'(v[3:0]) : int'(v[3:0]);
  endfunction

  task automatic model(input int n, input int accw, output int acc, output int s);
    int mx, mn;
    mx = (1 << (accw - 1)) - 1;
    mn = -(1 << (accw - 1));
    acc = 0;
    s = 0;
    for (int i = 0; i < n; i++) begin
      acc += sm2i(xd[i]) * sm2i(wd[i]);
      if (acc > mx) begin acc = mx; s = 1; end
      else if (acc < mn) begin acc = mn; s = 1; end
    end
  endtask

  task automatic run(input int s, input int n, output int lat);
    @(negedge clk);
    chk("done_low_before_start", g_done(s), 0);
    st[s] = 1'b1;
    @(negedge clk);
    st[s] = 1'b0;
    lat = 1;
    chk("acc_cleared_on_accept", g_acc(s), 0);
    while (g_done(s) == 0 && lat < 40) begin
      chk("busy", g_busy(s), 1);
      if (s == 0 && lat <= n) chk("idx", int'(idx0), lat - 1);
      if (s == 0 && lat >= 2 && lat <= n + 1) begin
        chk("mult_a", int'(a0), int'(xd[lat-2]));
        chk("mult_b", int'(b0), int'(wd[lat-2]));
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, n + 2);
    chk("busy_in_done", g_busy(s), 0);
  endtask

  typedef struct {
    logic [19:0] x;
    logic [19:0] w;
    int acc;
    int sat;
  } vec_t;
  vec_t tbl[4];

  task automatic load(input logic [19:0] x, input logic [19:0] w);
    for (int i = 0; i < 4; i++) begin
      xd[i] = x[5*i+:5];
      wd[i] = w[5*i+:5];
    end
  endtask

  initial begin
    int lat, ea, es, dn;
    tbl[0] = '{x: {5'd15, 5'b10010, 5'd5, 5'd3}, w: {5'd15, 5'd7, 5'b10001, 5'd2}, acc: 212, sat: 0};
    tbl[1] = '{x: {5'd1, 5'd1, 5'd1, 5'b10000}, w: {5'b10001, 5'b10001, 5'b10001, 5'd5}, acc: -3, sat: 0};
    tbl[2] = '{x: {4{5'd15}}, w: {4{5'd15}}, acc: 900, sat: 0};
    tbl[3] = '{x: {4{5'd15}}, w: {4{5'b11111}}, acc: -900, sat: 0};
    load(tbl[0].x, tbl[0].w);
    repeat (3) @(negedge clk);
    chk("rst_idx", int'(idx0), 0);
    chk("rst_mult_a", int'(a0), 0);
    chk("rst_mult_b", int'(b0), 0);
    chk("rst_acc", g_acc(0), 0);
    chk("rst_busy", g_busy(0), 0);
    chk("rst_done", g_done(0), 0);
    chk("rst_sat", g_sat(0), 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      load(tbl[i].x, tbl[i].w);
      run(0, 4, lat);
      chk("tbl_acc", g_acc(0), tbl[i].acc);
      chk("tbl_sat", g_sat(0), tbl[i].sat);
    end

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) begin
        xd[i] = 5'($urandom);
        wd[i] = 5'($urandom);
      end
      model(4, 12, ea, es);
      run(0, 4, lat);
      chk("rnd12_acc", g_acc(0), ea);
      chk("rnd12_sat", g_sat(0), es);
    end
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) begin
        xd[i] = 5'($urandom);
        wd[i] = 5'($urandom);
      end
      model(4, 8, ea, es);
      run(1, 4, lat);
      chk("rnd8_acc", g_acc(1), ea);
      chk("rnd8_sat", g_sat(1), es);
    end

    load(tbl[2].x, tbl[2].w);
    run(1, 4, lat);
    chk("sat8_pos_acc", g_acc(1), 127);
    chk("sat8_pos_sat", g_sat(1), 1);
    load(tbl[3].x, tbl[3].w);
    run(1, 4, lat);
    chk("sat8_neg_acc", g_acc(1), -128);
    chk("sat8_neg_sat", g_sat(1), 1);
    load({4{5'd15}}, {5'd15, 5'b11111, 5'b11111, 5'd15});
    run(1, 4, lat);
    chk("sat8_continue_acc", g_acc(1), 97);
    chk("sat8_continue_sat", g_sat(1), 1);
    load(tbl[1].x, tbl[1].w);
    run(1, 4, lat);
    chk("sat8_clear_acc", g_acc(1), -3);
    chk("sat8_clear_sat", g_sat(1), 0);

    xd[0] = 5'b11111;
    wd[0] = 5'd15;
    run(2, 1, lat);
    chk("n1_acc", g_acc(2), -225);

    load(tbl[0].x, tbl[0].w);
    @(negedge clk);
    st[0] = 1'b1;
    dn = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      st[0] = (c == 2 || c == 5);
      dn += g_done(0);
      if (c == 6) begin
        chk("ign_done_t6", g_done(0), 1);
        chk("ign_acc_t6", g_acc(0), 212);
      end
    end
    st[0] = 1'b0;
    chk("ign_done_count", dn, 1);
    chk("ign_busy_after", g_busy(0), 0);
    chk("ign_acc_held", g_acc(0), 212);

    load(tbl[1].x, tbl[1].w);
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", g_busy(0), 0);
    chk("abort_acc", g_acc(0), 0);
    chk("abort_idx", int'(idx0), 0);
    dn = 0;
    repeat (8) begin
      dn += g_done(0);
      @(negedge clk);
    end
    chk("abort_no_done", dn, 0);
    load(tbl[0].x, tbl[0].w);
    run(0, 4, lat);
    chk("after_abort_acc", g_acc(0), 212);

    load(tbl[2].x, tbl[2].w);
    run(0, 4, lat);
    chk("b2b_first_acc", g_acc(0), 900);
    load(tbl[1].x, tbl[1].w);
    run(0, 4, lat);
    chk("b2b_second_acc", g_acc(0), -3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
